// File: rtl/mpu_reader_pkg.sv
// Shared definitions for the NT35510 MPU read path.
// Contains the bus levels, the read opcodes and the strobe phase width.
package mpu_reader_pkg;

    // Panel pin levels: chip select / strobe active low, DCX low selects a command
    localparam logic SEL = 1'b0;
    localparam logic DES = 1'b1;
    localparam logic CMD = 1'b0;
    localparam logic DAT = 1'b1;

    localparam logic [15:0] RDDID = 16'h0400;
    localparam logic [15:0] RAMRD = 16'h2E00;

    localparam int PHASE_W = 6;

    function automatic logic [PHASE_W-1:0] to_phase(input int len);
        return len[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/mpu_strobe_timer.sv
// Phase counter for one strobe period: TL cycles low, then TH cycles high.
// It wraps to zero on its own at the end of each period, so back-to-back strobes need no restart.
module mpu_strobe_timer
    import mpu_reader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               run_i,
    input  logic [PHASE_W-1:0] tl_i,
    input  logic [PHASE_W-1:0] th_i,
    output logic               low_end_o,
    output logic               high_end_o
);

    localparam logic [PHASE_W-1:0] PH_ONE  = 1;
    localparam logic [PHASE_W:0]   EXT_ONE = 1;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W:0]   low_last, high_last;

    assign low_last  = {1'b0, tl_i} - EXT_ONE;
    assign high_last = {1'b0, tl_i} + {1'b0, th_i} - EXT_ONE;

    assign low_end_o  = run_i && ({1'b0, phase_q} == low_last);
    assign high_end_o = run_i && ({1'b0, phase_q} == high_last);

    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (run_i) begin
            phase_d = high_end_o ? '0 : phase_q + PH_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/mpu_reader.sv
// NT35510 8080-bus read controller: one command write, then N RDX read strobes with data capture.
// Build option MPU_RD_DUMMY_EN: a discarded dummy strobe precedes the data words.
module mpu_reader
    import mpu_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 8,
    parameter int TWRL       = 4,
    parameter int TWRH       = 4,
    parameter int TRDL       = 4,
    parameter int TRDH       = 4
) (
    input  logic                  i_arst,
    input  logic                  i_sysclk,
    input  logic                  i_start,
    input  logic [15:0]           i_cmd,
    input  logic [CNT_WIDTH-1:0]  i_count,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_csx,
    output logic                  o_dcx,
    output logic                  o_wrx,
    output logic                  o_rdx,
    output logic [DATA_WIDTH-1:0] o_d,
    output logic [DATA_WIDTH-1:0] o_oe
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMDWR  = 3'd1;
    localparam logic [2:0] S_DUMMY  = 3'd2;
    localparam logic [2:0] S_RDDAT  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

`ifdef MPU_RD_DUMMY_EN
    localparam logic [2:0] S_FIRST_RD = S_DUMMY;
`else
    localparam logic [2:0] S_FIRST_RD = S_RDDAT;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  csx_q, csx_d, dcx_q, dcx_d, wrx_q, wrx_d, rdx_q, rdx_d;
    logic [DATA_WIDTH-1:0] d_q, d_d, oe_q, oe_d, data_q, data_d;
    logic                  valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic               tmr_clr, tmr_run, low_end, high_end;
    logic [PHASE_W-1:0] tmr_tl, tmr_th;

    mpu_strobe_timer u_timer (
        .clk_i      (i_sysclk),
        .rst_i      (i_arst),
        .clr_i      (tmr_clr),
        .run_i      (tmr_run),
        .tl_i       (tmr_tl),
        .th_i       (tmr_th),
        .low_end_o  (low_end),
        .high_end_o (high_end)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csx_d   = csx_q;
        dcx_d   = dcx_q;
        wrx_d   = wrx_q;
        rdx_d   = rdx_q;
        d_d     = d_q;
        oe_d    = oe_q;
        data_d  = data_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_run = 1'b0;
        tmr_tl  = to_phase(TRDL);
        tmr_th  = to_phase(TRDH);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CMDWR;
                    cnt_d   = i_count;
                    csx_d   = SEL;
                    dcx_d   = CMD;
                    wrx_d   = SEL;
                    d_d     = {{(DATA_WIDTH-16){1'b0}}, i_cmd};
                    oe_d    = '1;
                    busy_d  = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            S_CMDWR: begin
                tmr_run = 1'b1;
                tmr_tl  = to_phase(TWRL);
                tmr_th  = to_phase(TWRH);
                if (low_end) begin
                    wrx_d = DES;
                end
                // Release the bus on the same edge RDX first drops, so drive and read never overlap
                if (high_end) begin
                    oe_d  = '0;
                    d_d   = '0;
                    dcx_d = DAT;
                    if (cnt_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        rdx_d   = SEL;
                        state_d = S_FIRST_RD;
                    end
                end
            end
            S_DUMMY: begin
                tmr_run = 1'b1;
                if (low_end) begin
                    rdx_d = DES;
                end
                if (high_end) begin
                    rdx_d   = SEL;
                    state_d = S_RDDAT;
                end
            end
            S_RDDAT: begin
                tmr_run = 1'b1;
                // Count is decremented at the sample so it holds the words still owed at period end
                if (low_end) begin
                    rdx_d   = DES;
                    data_d  = i_d;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - CNT_ONE;
                end
                if (high_end) begin
                    if (cnt_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        rdx_d = SEL;
                    end
                end
            end
            S_FINISH: begin
                csx_d   = DES;
                rdx_d   = DES;
                dcx_d   = DAT;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            csx_q   <= DES;
            dcx_q   <= DAT;
            wrx_q   <= DES;
            rdx_q   <= DES;
            d_q     <= '0;
            oe_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csx_q   <= csx_d;
            dcx_q   <= dcx_d;
            wrx_q   <= wrx_d;
            rdx_q   <= rdx_d;
            d_q     <= d_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_csx   = csx_q;
    assign o_dcx   = dcx_q;
    assign o_wrx   = wrx_q;
    assign o_rdx   = rdx_q;
    assign o_d     = d_q;
    assign o_oe    = oe_q;

endmodule

// File: tb/tb_mpu_reader.sv
// Scoreboard bench for mpu_reader; adapts its expectations to MPU_RD_DUMMY_EN.
module tb_mpu_reader;
    import mpu_reader_pkg::*;

`ifdef MPU_RD_DUMMY_EN
    localparam int DUMMY = 1;
`else
    localparam int DUMMY = 0;
`endif
    localparam int TW = 8;
    localparam int TR = 8;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cmd = '0;
    logic [7:0]  count = '0;
    logic [23:0] din = '0;
    logic [23:0] data, d, oe;
    logic        valid, busy, done, csx, dcx, wrx, rdx;

    int errors = 0;
    int checks = 0;
    logic [23:0] resp [0:255];
    logic [23:0] sb [$];
    int strobe_idx = 0;

    mpu_reader dut (
        .i_arst   (arst),
        .i_sysclk (clk),
        .i_start  (start),
        .i_cmd    (cmd),
        .i_count  (count),
        .i_d      (din),
        .o_data   (data),
        .o_valid  (valid),
        .o_busy   (busy),
        .o_done   (done),
        .o_csx    (csx),
        .o_dcx    (dcx),
        .o_wrx    (wrx),
        .o_rdx    (rdx),
        .o_d      (d),
        .o_oe     (oe)
    );

    always #5 clk = ~clk;

    // Panel model: presents the next word on each RDX fall, dummy word first when enabled
    always @(negedge rdx or posedge csx) begin
        if (csx) begin
            strobe_idx = 0;
        end else begin
            din = (strobe_idx < DUMMY) ? 24'h5A5A5A : resp[strobe_idx - DUMMY];
            strobe_idx = strobe_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_txn(input logic [15:0] c, input int n, input bit disturb);
        int k, done_at, wrx_low, falls, nval, exp_done;
        logic prev_rdx, prev_busy;
        for (int i = 0; i < n; i++) sb.push_back(resp[i]);
        exp_done = TW + ((n > 0) ? (n + DUMMY) * TR : 0) + 1;
        @(negedge clk);
        start = 1'b1;
        cmd   = c;
        count = n[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("cmd_on_bus", d, {8'h00, c});
        check("oe_cmd", oe, 24'hFFFFFF);
        check("dcx_cmd", dcx, 0);
        k = 0;
        done_at = -1;
        wrx_low = (wrx == 1'b0) ? 1 : 0;
        falls = 0;
        nval = 0;
        prev_rdx = rdx;
        prev_busy = busy;
        while (done_at < 0 && k < 4000) begin
            prev_busy = busy;
            @(posedge clk);
            #1;
            k++;
            if (disturb && k == 20) begin
                start = 1'b1;
                cmd   = 16'h2E00;
                count = 8'd7;
            end
            if (disturb && k == 21) start = 1'b0;
            if (!wrx) wrx_low++;
            if (prev_rdx && !rdx) falls++;
            prev_rdx = rdx;
            if (!rdx) check("oe_while_rdx", oe, 0);
            if (valid) begin
                nval++;
                if (sb.size() > 0) check("rd_data", data, sb.pop_front());
                else check("valid_count", nval, n);
            end
            if (done) done_at = k;
        end
        check("done_cycle", done_at, exp_done);
        check("busy_before_done", prev_busy, 1);
        check("busy_at_done", busy, 0);
        check("csx_at_done", csx, 1);
        check("wrx_low_cycles", wrx_low, 4);
        check("rdx_pulses", falls, (n > 0) ? n + DUMMY : 0);
        check("valid_count", nval, n);
        check("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
    endtask

    task automatic run_reset_mid();
        int k, falls;
        logic prev_rdx;
        bit hit;
        for (int i = 0; i < 3; i++) sb.push_back(resp[i]);
        @(negedge clk);
        start = 1'b1;
        cmd   = RDDID;
        count = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        falls = 0;
        prev_rdx = rdx;
        hit = 1'b0;
        while (!hit && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (prev_rdx && !rdx) falls++;
            prev_rdx = rdx;
            if (valid && sb.size() > 0) check("pre_rst_data", data, sb.pop_front());
            if (falls == DUMMY + 2 && !rdx) hit = 1'b1;
        end
        check("rst_window_reached", hit, 1);
        #3 arst = 1'b1;
        #1;
        check("rst_csx", csx, 1);
        check("rst_dcx", dcx, 1);
        check("rst_wrx", wrx, 1);
        check("rst_rdx", rdx, 1);
        check("rst_oe", oe, 0);
        check("rst_d", d, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        sb.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_done_in_rst", done, 0);
        end
        @(negedge clk);
        arst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle_after_rst", busy, 0);
            check("no_done_after_rst", done, 0);
        end
    endtask

    initial begin
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_rst_csx", csx, 1);
        check("in_rst_busy", busy, 0);
        @(negedge clk);
        arst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_csx", csx, 1);
        check("idle_wrx", wrx, 1);
        check("idle_rdx", rdx, 1);
        check("idle_dcx", dcx, 1);
        check("idle_oe", oe, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", valid, 0);

        resp[0] = 24'hAA0000;
        resp[1] = 24'h00BB00;
        resp[2] = 24'h0000CC;
        run_txn(RDDID, 3, 1'b0);

        run_txn(RAMRD, 0, 1'b0);

        resp[0] = 24'h112233;
        resp[1] = 24'h445566;
        resp[2] = 24'h778899;
        run_txn(RDDID, 3, 1'b1);

        resp[0] = 24'hC0FFEE;
        resp[1] = 24'hBADA55;
        resp[2] = 24'h0DDBA1;
        run_reset_mid();

        resp[0] = 24'h13579B;
        resp[1] = 24'h2468AC;
        run_txn(RAMRD, 2, 1'b0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            resp[i] = {b, ~b, b ^ 8'h3C};
        end
        run_txn(RAMRD, 255, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_reader.md
Name: mpu_reader

Overview:
- 8080-style MPU read controller for the NT35510 panel bus; the read-direction companion to the existing MPU write path.
- Issues one command write (e.g. RDDID, RAMRD), then performs N RDX read strobes and captures the panel's data bus.
- Sits beside the write controller on the shared CSX/DCX/WRX/RDX/D pins; the top level muxes pins by o_busy.
- Used for panel ID check after init and for GRAM readback in the tester.

Parameters:
- DATA_WIDTH, 24, panel data bus width.
- CNT_WIDTH, 8, width of the read-word count.
- TWRL, 4, WRX low cycles for the command write.
- TWRH, 4, WRX high cycles for the command write.
- TRDL, 4, RDX low cycles per read.
- TRDH, 4, RDX high cycles per read.

Ports:
- i_arst  in  1  asynchronous active-high reset
- i_sysclk  in  1  system clock, all logic on rising edge
- i_start  in  1  start pulse, accepted only when o_busy=0
- i_cmd  in  16  command/register address, driven zero-extended on o_d
- i_count  in  CNT_WIDTH  data words to read, latched at start
- i_d  in  DATA_WIDTH  panel data bus input (pad input side)
- o_data  out  DATA_WIDTH  captured read word
- o_valid  out  1  one-cycle pulse, o_data valid
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse at transaction end
- o_csx/o_dcx/o_wrx/o_rdx  out  1 each  panel strobes
- o_d  out  DATA_WIDTH  panel data output
- o_oe  out  DATA_WIDTH  per-bit output enable, 1 = drive

Behaviour:
- Levels from nt35510.vh: SEL=0, DES=1, CMD=0, DAT=1; WRX and RDX idle at DES.
- Reset values: csx=wrx=rdx=1, dcx=1, o_d=0, o_oe=0, o_data=0, o_valid=o_done=o_busy=0, state IDLE, counters 0.
- States: IDLE, CMDWR, DUMMY, RDDAT, FINISH.
- IDLE, on i_start:
  - Next edge: csx=0, dcx=0, wrx=0, o_d={0,i_cmd}, o_oe=all 1, busy=1.
  - Latch i_count and reset the 6-bit phase counter.
  - Go to CMDWR.
- CMDWR:
  - wrx rises when phase==TWRL-1.
  - At phase==TWRL+TWRH-1: o_oe=0, o_d=0, dcx=1, rdx=0, phase=0.
  - Next state DUMMY if the feature is on, else RDDAT.
  - If latched count=0, go to FINISH instead and leave rdx=1.
- Read strobe, DUMMY and RDDAT:
  - rdx low for TRDL cycles.
  - At phase==TRDL-1: sample i_d and set rdx=1.
  - At phase==TRDL+TRDH-1: set rdx=0 for the next word, or go to FINISH after the last word.
- DUMMY: the sample is discarded and no o_valid is produced; then go to RDDAT.
- RDDAT: o_data<=i_d and o_valid=1 on the cycle after the sampling edge; decrement the remaining count.
- FINISH, one cycle: csx=1, rdx=1, dcx=1, o_done=1, busy=0; then IDLE.
- Total busy cycles = TWRL+TWRH + (N+dummy)*(TRDL+TRDH) + 1.
- i_start while busy is ignored; i_cmd and i_count are sampled only at acceptance.
- i_count=2^CNT_WIDTH-1 must read exactly that many words; the counter must not wrap.
- Async reset mid-transaction returns all outputs to reset values immediately, with no partial o_done.
- o_oe is never 1 while rdx=0, so there is no bus contention.

Optional Feature:
- Macro: MPU_RD_DUMMY_EN.
- Defined: one dummy RDX strobe precedes the data words, as the NT35510 read protocol requires; it produces no o_valid.
- Undefined: data capture starts with the first strobe; for panels or models without a dummy cycle.

Decomposition:
- nt35510.vh (shared): SEL/DES/CMD/DAT levels, plus read opcodes RDDID=16'h0400 and RAMRD=16'h2E00.
- State encodings stay local to this block.
- One natural sub-module, mpu_strobe_timer:
  - Inputs: TL/TH lengths and a start signal.
  - Outputs: phase count plus low_end and high_end pulses.
  - Shared by the CMDWR and read phases.

Test Plan:
- Reset then idle 10 cycles -> csx/wrx/rdx/dcx=1, oe=0, busy=0.
- Start cmd=16'h0400, count=3, dummy on, i_d model returns 24'hAA0000, 24'h00BB00, 24'h0000CC after one dummy -> exactly 3 o_valid with those values in order; o_done at cycle 41; wrx low 4 cycles; 4 rdx pulses.
- Same with MPU_RD_DUMMY_EN undefined -> 3 rdx pulses; done at cycle 33.
- count=0 -> command write only, no rdx pulse, no o_valid; done at cycle 9.
- i_start re-pulsed mid-read and a different i_cmd applied -> ignored; captured data and count unchanged.
- Assert i_arst while rdx=0 in word 2 -> all outputs at reset values same cycle; no o_done; a new start afterwards completes normally.
